// File: rtl/score_render_pkg.sv
// Shared constants and the 8x16 digit font for the score overlay.
package score_render_pkg;

  localparam int unsigned SCORE_WIDTH_DEC = 12;
  localparam int unsigned GLYPH_W         = 8;
  localparam int unsigned GLYPH_H         = 16;
  localparam logic [3:0]  BLANK_GLYPH     = 4'hF;

  // Each digit is 16 rows of 8 bits, row 0 in the top byte, bit 7 = leftmost column.
  localparam logic [127:0] FONT_0 = 128'h0000_7CC6_C6CE_DEF6_E6C6_C67C_0000_0000;
  localparam logic [127:0] FONT_1 = 128'h0000_1838_7818_1818_1818_187E_0000_0000;
  localparam logic [127:0] FONT_2 = 128'h0000_7CC6_060C_1830_60C0_C6FE_0000_0000;
  localparam logic [127:0] FONT_3 = 128'h0000_7CC6_0606_3C06_0606_C67C_0000_0000;
  localparam logic [127:0] FONT_4 = 128'h0000_0C1C_3C6C_CCFE_0C0C_0C1E_0000_0000;
  localparam logic [127:0] FONT_5 = 128'h0000_FEC0_C0C0_FC06_0606_C67C_0000_0000;
  localparam logic [127:0] FONT_6 = 128'h0000_3860_C0C0_FCC6_C6C6_C67C_0000_0000;
  localparam logic [127:0] FONT_7 = 128'h0000_FEC6_0606_0C18_3030_3030_0000_0000;
  localparam logic [127:0] FONT_8 = 128'h0000_7CC6_C6C6_7CC6_C6C6_C67C_0000_0000;
  localparam logic [127:0] FONT_9 = 128'h0000_7CC6_C6C6_7E06_0606_0C78_0000_0000;

  function automatic logic [7:0] font_row(input logic [3:0] digit, input logic [3:0] row);
    logic [127:0] g;
    logic [6:0]   base;
    case (digit)
      4'd0:    g = FONT_0;
      4'd1:    g = FONT_1;
      4'd2:    g = FONT_2;
      4'd3:    g = FONT_3;
      4'd4:    g = FONT_4;
      4'd5:    g = FONT_5;
      4'd6:    g = FONT_6;
      4'd7:    g = FONT_7;
      4'd8:    g = FONT_8;
      4'd9:    g = FONT_9;
      default: g = '0;
    endcase
    base = {4'(4'd15 - row), 3'd0};
    return g[base +: 8];
  endfunction

endpackage

// File: rtl/score_glyph_rom.sv
// Combinational digit font lookup; non-BCD codes render blank.
module score_glyph_rom
  import score_render_pkg::*;
(
  input  logic [3:0] nibble_i,
  input  logic [3:0] row_i,
  output logic [7:0] row_bits_o
);

  always_comb begin
    row_bits_o = 8'h00;
    if (nibble_i <= 4'd9) row_bits_o = font_row(nibble_i, row_i);
  end

endmodule

// File: rtl/score_render.sv
// Renders the frame-snapshotted BCD score as scaled glyphs; 2-cycle pixel pipeline.
module score_render
  import score_render_pkg::*;
#(
  parameter int unsigned ORIGIN_X   = 8,
  parameter int unsigned ORIGIN_Y   = 8,
  parameter int unsigned SCALE_LOG2 = 1
) (
  input  logic                       clk_vga,
  input  logic                       rst,
  input  logic [SCORE_WIDTH_DEC-1:0] score_i,
  input  logic [1:0]                 score_digit_i,
  input  logic                       frame_start_i,
  input  logic [9:0]                 pix_x_i,
  input  logic [9:0]                 pix_y_i,
  input  logic                       pix_valid_i,
  output logic                       score_pix_o,
  output logic                       score_pix_valid_o
);

  localparam int unsigned SLOT_SHIFT = SCALE_LOG2 + 3;
  localparam int unsigned DIGIT_W    = GLYPH_W << SCALE_LOG2;
  localparam int unsigned DIGIT_H    = GLYPH_H << SCALE_LOG2;

  logic [SCORE_WIDTH_DEC-1:0] shadow_score_q, shadow_score_d;
  logic [1:0]                 shadow_cnt_q, shadow_cnt_d;

  logic       s1_in_q, s1_in_d;
  logic [3:0] s1_nib_q, s1_nib_d;
  logic [3:0] s1_row_q, s1_row_d;
  logic [2:0] s1_col_q, s1_col_d;
  logic       s1_valid_q, s1_valid_d;

  logic       pix_q, pix_d;
  logic       pix_valid_q, pix_valid_d;

  logic [1:0]  n_digits;
  logic [1:0]  sel;
  logic [10:0] x_hi;
  logic [9:0]  dx, dy, slot;
  logic        in_x, in_y;
  logic [7:0]  row_bits;

  // Snapshot: the pixel coinciding with frame_start still sees the old shadow.
  always_comb begin
    shadow_score_d = shadow_score_q;
    shadow_cnt_d   = shadow_cnt_q;
    if (frame_start_i) begin
      shadow_score_d = score_i;
      shadow_cnt_d   = score_digit_i;
    end
  end

  // Stage 1: bounds on raw coordinates, so wrapped dx/dy below the origin never hit.
  always_comb begin
    n_digits = (shadow_cnt_q == 2'd0) ? 2'd1 : shadow_cnt_q;
    x_hi     = 11'(ORIGIN_X) + 11'(n_digits) * 11'(DIGIT_W);
    in_x     = ({1'b0, pix_x_i} >= 11'(ORIGIN_X)) && ({1'b0, pix_x_i} < x_hi);
    in_y     = ({1'b0, pix_y_i} >= 11'(ORIGIN_Y)) && ({1'b0, pix_y_i} < 11'(ORIGIN_Y + DIGIT_H));
    dx       = pix_x_i - 10'(ORIGIN_X);
    dy       = pix_y_i - 10'(ORIGIN_Y);
    slot     = dx >> SLOT_SHIFT;
    sel      = 2'(n_digits - 2'd1 - 2'(slot));

    s1_in_d    = pix_valid_i & in_x & in_y;
    s1_nib_d   = BLANK_GLYPH;
    if (slot < 10'(n_digits)) s1_nib_d = shadow_score_q[{sel, 2'b00} +: 4];
    s1_col_d   = 3'(dx >> SCALE_LOG2);
    s1_row_d   = 4'(dy >> SCALE_LOG2);
    s1_valid_d = pix_valid_i;
  end

  score_glyph_rom u_rom (
    .nibble_i   (s1_nib_q),
    .row_i      (s1_row_q),
    .row_bits_o (row_bits)
  );

  always_comb begin
    pix_d       = s1_in_q & row_bits[3'(3'd7 - s1_col_q)];
    pix_valid_d = s1_valid_q;
  end

  always_ff @(posedge clk_vga or posedge rst) begin
    if (rst) begin
      shadow_score_q <= '0;
      shadow_cnt_q   <= '0;
      s1_in_q        <= 1'b0;
      s1_nib_q       <= '0;
      s1_row_q       <= '0;
      s1_col_q       <= '0;
      s1_valid_q     <= 1'b0;
      pix_q          <= 1'b0;
      pix_valid_q    <= 1'b0;
    end else begin
      shadow_score_q <= shadow_score_d;
      shadow_cnt_q   <= shadow_cnt_d;
      s1_in_q        <= s1_in_d;
      s1_nib_q       <= s1_nib_d;
      s1_row_q       <= s1_row_d;
      s1_col_q       <= s1_col_d;
      s1_valid_q     <= s1_valid_d;
      pix_q          <= pix_d;
      pix_valid_q    <= pix_valid_d;
    end
  end

  assign score_pix_o       = pix_q;
  assign score_pix_valid_o = pix_valid_q;

endmodule

// File: tb/tb_score_render.sv
// Scoreboard bench for score_render: golden font model, 2-cycle expected-output queue.
module tb_score_render;

  logic        clk_vga = 1'b0;
  logic        rst;
  logic [11:0] score_i;
  logic [1:0]  score_digit_i;
  logic        frame_start_i;
  logic [9:0]  pix_x_i, pix_y_i;
  logic        pix_valid_i;
  logic        score_pix_o, score_pix_valid_o;

  always #5 clk_vga = ~clk_vga;

  score_render dut (
    .clk_vga           (clk_vga),
    .rst               (rst),
    .score_i           (score_i),
    .score_digit_i     (score_digit_i),
    .frame_start_i     (frame_start_i),
    .pix_x_i           (pix_x_i),
    .pix_y_i           (pix_y_i),
    .pix_valid_i       (pix_valid_i),
    .score_pix_o       (score_pix_o),
    .score_pix_valid_o (score_pix_valid_o)
  );

  typedef struct packed {logic v; logic p;} exp_t;
  exp_t         exp_q[$];
  int           n_tests = 0;
  int           n_fail  = 0;
  logic [11:0]  m_score;
  logic [1:0]   m_cnt;
  logic [127:0] font [10];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Golden model: ORIGIN 8,8, 16x32 digit cells, left-justified digits.
  function automatic logic model_pix(input int x, input int y, input logic v);
    int n, slot, nib, row, col;
    n = (m_cnt == 0) ? 1 : int'(m_cnt);
    if (!v || x < 8 || x >= 8 + 16 * n || y < 8 || y >= 40) return 1'b0;
    slot = (x - 8) / 16;
    nib  = int'((m_score >> (4 * (n - 1 - slot))) & 12'hF);
    if (nib > 9) return 1'b0;
    row = (y - 8) / 2;
    col = ((x - 8) / 2) % 8;
    return font[nib][127 - 8 * row - col];
  endfunction

  task automatic cycle(input int x, input int y, input logic v, input logic fs, input string tag);
    exp_t e;
    pix_x_i       = 10'(x);
    pix_y_i       = 10'(y);
    pix_valid_i   = v;
    frame_start_i = fs;
    e.v = v;
    e.p = model_pix(x, y, v);
    exp_q.push_back(e);
    if (fs) begin
      m_score = score_i;
      m_cnt   = score_digit_i;
    end
    @(posedge clk_vga);
    @(negedge clk_vga);
    if (exp_q.size() == 2) begin
      e = exp_q.pop_front();
      check({tag, "_valid"}, 32'(score_pix_valid_o), 32'(e.v));
      check({tag, "_pix"}, 32'(score_pix_o), 32'(e.p));
    end
  endtask

  task automatic scan(input int y0, input int y1, input bit rnd, input string tag);
    for (int y = y0; y <= y1; y++)
      for (int x = 0; x < 64; x++)
        cycle(x, y, rnd ? 1'($urandom_range(0, 1)) : 1'b1, 1'b0, tag);
  endtask

  task automatic frame(input logic [11:0] sc, input logic [1:0] cnt);
    score_i       = sc;
    score_digit_i = cnt;
    cycle(0, 0, 1'b0, 1'b1, "fs");
  endtask

  initial begin
    font[0] = 128'h0000_7CC6_C6CE_DEF6_E6C6_C67C_0000_0000;
    font[1] = 128'h0000_1838_7818_1818_1818_187E_0000_0000;
    font[2] = 128'h0000_7CC6_060C_1830_60C0_C6FE_0000_0000;
    font[3] = 128'h0000_7CC6_0606_3C06_0606_C67C_0000_0000;
    font[4] = 128'h0000_0C1C_3C6C_CCFE_0C0C_0C1E_0000_0000;
    font[5] = 128'h0000_FEC0_C0C0_FC06_0606_C67C_0000_0000;
    font[6] = 128'h0000_3860_C0C0_FCC6_C6C6_C67C_0000_0000;
    font[7] = 128'h0000_FEC6_0606_0C18_3030_3030_0000_0000;
    font[8] = 128'h0000_7CC6_C6C6_7CC6_C6C6_C67C_0000_0000;
    font[9] = 128'h0000_7CC6_C6C6_7E06_0606_0C78_0000_0000;
    m_score = '0;
    m_cnt   = '0;

    rst = 1'b1; score_i = 12'h999; score_digit_i = 2'd3; frame_start_i = 1'b0;
    pix_x_i = 10'd12; pix_y_i = 10'd12; pix_valid_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk_vga);
      check("rst_pix", 32'(score_pix_o), 32'd0);
      check("rst_valid", 32'(score_pix_valid_o), 32'd0);
    end
    rst = 1'b0;

    scan(0, 47, 1'b0, "post_rst_zero");
    frame(12'h000, 2'd0);
    scan(0, 47, 1'b0, "zero");

    frame(12'h123, 2'd3);
    scan(0, 47, 1'b0, "s123");

    frame(12'h047, 2'd2);
    scan(0, 47, 1'b0, "s047");

    frame(12'h005, 2'd1);
    scan(0, 23, 1'b0, "s5_top");
    score_i = 12'h006;
    scan(24, 47, 1'b0, "s5_bot");
    cycle(12, 20, 1'b1, 1'b1, "fs_active");
    scan(0, 47, 1'b0, "s6");

    frame(12'h000, 2'd0);
    scan(0, 47, 1'b1, "rnd_valid");

    frame(12'h00A, 2'd1);
    scan(0, 47, 1'b0, "non_bcd");

    frame(12'h888, 2'd3);
    scan(8, 15, 1'b0, "s888");
    cycle(12, 20, 1'b1, 1'b0, "pre_rst");
    cycle(12, 20, 1'b1, 1'b0, "pre_rst");
    rst = 1'b1;
    @(posedge clk_vga);
    @(negedge clk_vga);
    check("midrst_pix", 32'(score_pix_o), 32'd0);
    check("midrst_valid", 32'(score_pix_valid_o), 32'd0);
    rst = 1'b0;
    exp_q.delete();
    m_score = '0;
    m_cnt   = '0;
    scan(8, 39, 1'b0, "after_rst");
    cycle(0, 0, 1'b0, 1'b0, "flush");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
